// File: rtl/i2c_led_ctrl.sv
// i2c_led_ctrl: I2C byte stream to pixel memory writer with refresh handshake; fill mode via LED_CTRL_FILL_EN
module i2c_led_ctrl #(
  parameter int NUM_LEDS = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             mem_we_o,
  output logic [IDX_W-1:0] mem_addr_o,
  output logic [23:0]      mem_wdata_o,
  output logic             refresh_req_o,
  input  logic             refresh_busy_i,
  output logic             frame_err_o
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LEDS - 1);
  localparam logic [7:0] N8 = 8'(NUM_LEDS);
  typedef enum logic [2:0] {IDLE, CMD, DATA, DROP
`ifdef LED_CTRL_FILL_EN
    , FILL
`endif
  } state_t;
  state_t           r_state, w_nxt;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [1:0]       r_cnt, w_cnt;
  logic [15:0]      r_asm;
  logic             r_wrote, r_pending, r_we, r_req, r_err, w_wr;
  logic [IDX_W-1:0] r_addr;
  logic [23:0]      r_wdata, w_wdata;
`ifdef LED_CTRL_FILL_EN
  logic             r_fill, r_start_l, r_stop_l, w_st, w_sp;
  logic [IDX_W-1:0] w_nidx;
  assign w_st = r_start_l | start_i;
  assign w_sp = r_stop_l | stop_i;
  assign w_nidx = r_idx + 1'b1;
`endif
  assign mem_we_o = r_we;
  assign mem_addr_o = r_addr;
  assign mem_wdata_o = r_wdata;
  assign refresh_req_o = r_req;
  assign frame_err_o = r_err;
  always_comb begin
    w_nxt = r_state;
    w_idx = r_idx;
    w_cnt = r_cnt;
    w_wr = 1'b0;
    w_wdata = {r_asm, data_i};
    if (data_valid_i && r_state == CMD) begin
      w_idx = data_i[IDX_W-1:0];
      w_nxt = ({1'b0, data_i[6:0]} >= N8) ? DROP : DATA;
      w_cnt = 2'd0;
    end else if (data_valid_i && r_state == DATA) begin
      w_wr = r_cnt == 2'd2;
      w_cnt = w_wr ? 2'd0 : r_cnt + 2'd1;
      if (w_wr) begin
`ifdef LED_CTRL_FILL_EN
        if (r_fill) w_nxt = (r_idx == LAST) ? DROP : FILL;
        else
`endif
        w_idx = (r_idx == LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_cnt <= '0;
      r_asm <= '0;
      r_wrote <= 1'b0;
      r_pending <= 1'b0;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_req <= 1'b0;
      r_err <= 1'b0;
`ifdef LED_CTRL_FILL_EN
      r_fill <= 1'b0;
      r_start_l <= 1'b0;
      r_stop_l <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
      r_err <= 1'b0;
      // a frame ending on the acknowledge edge re-arms pending below
      if (r_req) begin
        if (refresh_busy_i) begin
          r_req <= 1'b0;
          r_pending <= 1'b0;
        end
      end else if (r_pending && !refresh_busy_i && r_state == IDLE) r_req <= 1'b1;
      case (r_state)
        IDLE: if (start_i) begin
          r_state <= CMD;
          r_wrote <= 1'b0;
          r_cnt <= '0;
        end
`ifdef LED_CTRL_FILL_EN
        FILL: begin
          r_we <= 1'b1;
          r_addr <= w_nidx;
          r_idx <= w_nidx;
          if (w_nidx == LAST) begin
            r_state <= w_st ? CMD : (w_sp ? IDLE : DROP);
            r_start_l <= 1'b0;
            r_stop_l <= 1'b0;
            if (w_sp) begin
              r_pending <= 1'b1;
              r_wrote <= 1'b0;
            end
          end else begin
            r_start_l <= w_st;
            r_stop_l <= w_sp;
          end
        end
`endif
        default: begin
          r_state <= w_nxt;
          r_idx <= w_idx;
          r_cnt <= w_cnt;
          if (data_valid_i && r_state == DATA) r_asm <= {r_asm[7:0], data_i};
`ifdef LED_CTRL_FILL_EN
          if (data_valid_i && r_state == CMD) r_fill <= data_i[7];
`endif
          if (w_wr) begin
            r_we <= 1'b1;
            r_addr <= r_idx;
            r_wdata <= w_wdata;
            r_wrote <= 1'b1;
          end
`ifdef LED_CTRL_FILL_EN
          if (w_nxt == FILL) begin
            r_start_l <= start_i;
            r_stop_l <= stop_i;
          end else
`endif
          if (start_i) begin
            r_state <= CMD;
            r_cnt <= '0;
            r_err <= w_cnt != 2'd0;
          end else if (stop_i) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_err <= w_cnt != 2'd0;
            r_wrote <= 1'b0;
            if (r_wrote || w_wr) r_pending <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_led_ctrl.sv
// tb_i2c_led_ctrl: directed self-checking bench for i2c_led_ctrl
module tb_i2c_led_ctrl;
  logic clk = 0, reset = 0;
  logic [7:0] data_i = 0;
  logic data_valid_i = 0, start_i = 0, stop_i = 0, refresh_busy_i = 0;
  logic mem_we_o, refresh_req_o, frame_err_o;
  logic [3:0] mem_addr_o;
  logic [23:0] mem_wdata_o;
  int n_tests = 0, n_fail = 0, n_err = 0, n_rise = 0, cyc = 0;
  logic prev_req = 0;
  logic [3:0] wa[$];
  logic [23:0] wd[$];
  int wt[$];
  always #5 clk = ~clk;
  i2c_led_ctrl #(.NUM_LEDS(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .data_valid_i(data_valid_i),
    .start_i(start_i), .stop_i(stop_i), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .refresh_req_o(refresh_req_o),
    .refresh_busy_i(refresh_busy_i), .frame_err_o(frame_err_o)
  );
  always @(negedge clk) begin
    cyc++;
    if (mem_we_o) begin
      wa.push_back(mem_addr_o);
      wd.push_back(mem_wdata_o);
      wt.push_back(cyc);
    end
    if (frame_err_o) n_err++;
    if (refresh_req_o && !prev_req) n_rise++;
    prev_req = refresh_req_o;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data_i = b;
    data_valid_i = 1;
    @(negedge clk);
    data_valid_i = 0;
  endtask
  task automatic pulse_start();
    @(negedge clk);
    start_i = 1;
    @(negedge clk);
    start_i = 0;
  endtask
  task automatic pulse_stop();
    @(negedge clk);
    stop_i = 1;
    @(negedge clk);
    stop_i = 0;
  endtask
  task automatic clr();
    wa.delete();
    wd.delete();
    wt.delete();
    n_err = 0;
    n_rise = 0;
  endtask
  task automatic wait_req(input logic lvl);
    for (int i = 0; i < 20 && refresh_req_o !== lvl; i++) @(negedge clk);
    chk("req_wait", refresh_req_o, lvl);
  endtask
  task automatic ack();
    wait_req(1);
    refresh_busy_i = 1;
    @(negedge clk);
    chk("req_fall", refresh_req_o, 0);
    refresh_busy_i = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {mem_we_o, mem_addr_o, mem_wdata_o, refresh_req_o, frame_err_o}, 0);
  endtask
  task automatic normal_frame();
    clr();
    pulse_start();
    send(8'h00);
    send(8'hAB);
    send(8'h36);
    send(8'h84);
    chk("we_lat", mem_we_o, 1);
    chk("we_addr", mem_addr_o, 0);
    chk("we_data", mem_wdata_o, 24'hAB3684);
    send(8'hD0);
    send(8'h25);
    send(8'h5A);
    send(8'h00);
    send(8'h77);
    send(8'h0D);
    pulse_stop();
    chk("req_early", refresh_req_o, 0);
    @(negedge clk);
    chk("req_rise", refresh_req_o, 1);
    chk("nf_cnt", wa.size(), 3);
    chk("nf_a1", wa[1], 1);
    chk("nf_d1", wd[1], 24'hD0255A);
    chk("nf_a2", wa[2], 2);
    chk("nf_d2", wd[2], 24'h00770D);
    chk("nf_err", n_err, 0);
    ack();
    tick(3);
    chk("nf_rise", n_rise, 1);
  endtask
  initial begin
    tick(2);
    chk_zero("reset_out");
    reset = 1;
    tick(2);
    normal_frame();
    clr();
    pulse_start();
    send(8'h05);
    send(8'h11);
    send(8'h22);
    pulse_stop();
    chk("err_pulse", frame_err_o, 1);
    tick(6);
    chk("pt_wr", wa.size(), 0);
    chk("pt_err", n_err, 1);
    chk("pt_rise", n_rise, 0);
    clr();
    pulse_start();
    send(8'h0F);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    send(8'h05);
    send(8'h06);
    pulse_stop();
    tick(2);
    chk("wr_cnt", wa.size(), 2);
    chk("wr_a0", wa[0], 4'hF);
    chk("wr_d0", wd[0], 24'h010203);
    chk("wr_a1", wa[1], 0);
    chk("wr_d1", wd[1], 24'h040506);
    ack();
    clr();
    pulse_start();
    send(8'h8C);
    send(8'h01);
    send(8'h02);
    send(8'h03);
`ifdef LED_CTRL_FILL_EN
    send(8'h99);
    pulse_stop();
    tick(2);
    chk("fill_cnt", wa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("fill_addr", wa[i], 12 + i);
      chk("fill_data", wd[i], 24'h010203);
      chk("fill_cyc", wt[i] - wt[0], i);
    end
`else
    pulse_stop();
    tick(2);
    chk("b7_cnt", wa.size(), 1);
    chk("b7_addr", wa[0], 4'hC);
    chk("b7_data", wd[0], 24'h010203);
`endif
    chk("fill_err", n_err, 0);
    ack();
    tick(3);
    chk("fill_rise", n_rise, 1);
    clr();
    pulse_start();
    send(8'h14);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    pulse_stop();
    tick(6);
    chk("oor_wr", wa.size(), 0);
    chk("oor_err", n_err, 0);
    chk("oor_rise", n_rise, 0);
    clr();
    pulse_start();
    send(8'h00);
    send(8'h01);
    send(8'h01);
    send(8'h01);
    pulse_stop();
    wait_req(1);
    refresh_busy_i = 1;
    @(negedge clk);
    chk("hs_fall", refresh_req_o, 0);
    pulse_start();
    send(8'h01);
    send(8'h02);
    send(8'h02);
    send(8'h02);
    pulse_stop();
    tick(6);
    chk("hs_hold", refresh_req_o, 0);
    chk("hs_rise1", n_rise, 1);
    refresh_busy_i = 0;
    @(negedge clk);
    chk("hs_rerise", refresh_req_o, 1);
    refresh_busy_i = 1;
    @(negedge clk);
    chk("hs_fall2", refresh_req_o, 0);
    refresh_busy_i = 0;
    tick(3);
    chk("hs_rise2", n_rise, 2);
    chk("hs_wr", wa.size(), 2);
    chk("hs_a1", wa[1], 1);
    chk("hs_d1", wd[1], 24'h020202);
    clr();
    pulse_start();
    send(8'h00);
    send(8'hAA);
    send(8'hBB);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk_zero("mid_reset");
    tick(4);
    chk("mr_wr", wa.size(), 0);
    chk("mr_rise", n_rise, 0);
    normal_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
